// File: rtl/zorro_pkg.sv
// Shared definitions for the Zorro II AUTOCONFIG responder: config state,
// bus-region and register-offset constants, and the board size code.
package zorro_pkg;

  typedef enum logic [1:0] {
    CfgUnconf,
    CfgConf,
    CfgShutup
  } cfg_st_e;

  // A23:16 of the AUTOCONFIG space at $E80000
  localparam logic [7:0] CfgRegionHi = 8'hE8;

  // Byte offsets within the config space
  localparam logic [6:0] OffsBase   = 7'h48;
  localparam logic [6:0] OffsShutup = 7'h4C;
  localparam logic [6:0] OffsRegEnd = 7'h40;

  // er_Type size field for a Zorro II board
  function automatic logic [3:0] size_code(int unsigned size_mb);
    logic [3:0] code;
    case (size_mb)
      1:       code = 4'h5;
      2:       code = 4'h6;
      4:       code = 4'h7;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/zorro_cfg_rom.sv
// Combinational AUTOCONFIG read nibble map, indexed by word address A6:1.
module zorro_cfg_rom
  import zorro_pkg::*;
#(
  parameter int unsigned SIZE_MB  = 8,
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PRODUCT  = 8'h01
) (
  input  logic [5:0] idx_i,
  output logic [3:0] nibble_o
);

  logic [6:0] offs;
  assign offs = {idx_i, 1'b0};

  always_comb begin
    nibble_o = 4'hF;
    if (offs >= OffsRegEnd) begin
      nibble_o = 4'h0;
    end else begin
      case (offs)
        7'h00:   nibble_o = 4'hE;
        7'h02:   nibble_o = size_code(SIZE_MB);
        7'h04:   nibble_o = ~PRODUCT[7:4];
        7'h06:   nibble_o = ~PRODUCT[3:0];
        7'h10:   nibble_o = ~MANUF_ID[15:12];
        7'h12:   nibble_o = ~MANUF_ID[11:8];
        7'h14:   nibble_o = ~MANUF_ID[7:4];
        7'h16:   nibble_o = ~MANUF_ID[3:0];
        default: nibble_o = 4'hF;
      endcase
    end
  end

endmodule

// File: rtl/zorro2_autoconfig_ram.sv
// Registered Zorro II AUTOCONFIG responder and fast-RAM window decoder.
// Hits are latched at AS_n fall and gated with live AS_n for zero-cycle release.
module zorro2_autoconfig_ram
  import zorro_pkg::*;
#(
  parameter int unsigned SIZE_MB  = 8,
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PRODUCT  = 8'h01
) (
  input  logic       M68K_CLK,
  input  logic       M68K_RESET_n,
  input  logic [7:0] A_HI,
  input  logic [5:0] A_LO,
  input  logic [3:0] D_IN,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       RW,
  input  logic       CONFIG_IN_n,
  output logic       CONFIG_OUT_n,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic       DTACK_RANGE,
  output logic       RAMCE
);

  cfg_st_e    cfg_st_q, cfg_st_d;
  logic [3:0] base_q, base_d;
  logic [5:0] idx_q, idx_d;
  logic       hit_cfg_q, hit_cfg_d;
  logic       hit_ram_q, hit_ram_d;
  logic       as_n_q, uds_n_q;

  logic       cyc_start;
  logic       wr_commit;
  logic [6:0] wr_offs;
  logic [4:0] ram_lo, ram_hi, addr_nib;
  logic [3:0] rom_nibble;

  assign cyc_start = !AS_n && as_n_q;

  // Five-bit compare so a window ending past $F does not wrap
  assign addr_nib = {1'b0, A_HI[7:4]};
  assign ram_lo   = {1'b0, base_q};
  assign ram_hi   = ram_lo + 5'(SIZE_MB);

  always_comb begin
    hit_cfg_d = hit_cfg_q;
    hit_ram_d = hit_ram_q;
    idx_d     = idx_q;
    if (AS_n) begin
      hit_cfg_d = 1'b0;
      hit_ram_d = 1'b0;
    end else if (cyc_start) begin
      hit_cfg_d = (A_HI == CfgRegionHi) && (cfg_st_q == CfgUnconf) && !CONFIG_IN_n;
      hit_ram_d = (cfg_st_q == CfgConf) && (addr_nib >= ram_lo) && (addr_nib < ram_hi);
      idx_d     = A_LO;
    end
  end

  // Commit uses this edge's decode so a simultaneous AS_n/UDS_n fall still writes
  always_comb begin
    wr_offs   = {idx_d, 1'b0};
    wr_commit = !UDS_n && uds_n_q && hit_cfg_d && !RW;
    cfg_st_d  = cfg_st_q;
    base_d    = base_q;
    if (wr_commit) begin
      if (wr_offs == OffsBase) begin
        base_d   = D_IN;
        cfg_st_d = CfgConf;
      end else if (wr_offs == OffsShutup) begin
        cfg_st_d = CfgShutup;
      end
    end
  end

  // Strobe history resets to "low" so a strobe held low across reset release
  // is not mistaken for a new cycle
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      cfg_st_q  <= CfgUnconf;
      base_q    <= 4'h0;
      idx_q     <= 6'h00;
      hit_cfg_q <= 1'b0;
      hit_ram_q <= 1'b0;
      as_n_q    <= 1'b0;
      uds_n_q   <= 1'b0;
    end else begin
      cfg_st_q  <= cfg_st_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      hit_cfg_q <= hit_cfg_d;
      hit_ram_q <= hit_ram_d;
      as_n_q    <= AS_n;
      uds_n_q   <= UDS_n;
    end
  end

  zorro_cfg_rom #(
    .SIZE_MB  (SIZE_MB),
    .MANUF_ID (MANUF_ID),
    .PRODUCT  (PRODUCT)
  ) u_cfg_rom (
    .idx_i    (idx_q),
    .nibble_o (rom_nibble)
  );

  assign CONFIG_OUT_n = (cfg_st_q == CfgUnconf);
  assign D_OUT        = hit_cfg_q ? rom_nibble : 4'hF;
  assign D_OE         = hit_cfg_q && RW && !AS_n;
  assign DTACK_RANGE  = (hit_cfg_q || hit_ram_q) && !AS_n;
  assign RAMCE        = hit_ram_q && !AS_n;

endmodule

// File: doc/zorro2_autoconfig_ram.md
# zorro2_autoconfig_ram

Clocked Zorro II AUTOCONFIG responder and fast-RAM decoder that feeds the PiStorm'X top level's RAM hooks. It replaces the combinational RAM decode with a registered state machine on M68K_CLK:
- presents the configuration nibbles at $E80000;
- accepts the base-address and shut-up writes;
- drives the daisy chain;
- flags accesses that hit the configured RAM window.

Its outputs drive the top level's RAM data-override, DTACK-range and RAMCE signals directly.

## Interface
Parameters:
- SIZE_MB, 8: board size in MB; legal 1, 2, 4, 8.
- MANUF_ID, 16'h07DB: manufacturer ID, returned inverted.
- PRODUCT, 8'h01: product number, returned inverted.

Ports (M68K_CLK is the only clock):
- M68K_CLK  in  1  7 MHz 68000 bus clock; all state changes on its rising edge.
- M68K_RESET_n  in  1  asynchronous, active-low reset.
- A_HI  in  8  M68K_A[23:16].
- A_LO  in  6  M68K_A[6:1]; register index within the config space.
- D_IN  in  4  M68K_D[15:12]; write data.
- AS_n  in  1  address strobe.
- UDS_n  in  1  upper data strobe.
- RW  in  1  1 = read.
- CONFIG_IN_n  in  1  daisy-chain enable; low = this board may configure.
- CONFIG_OUT_n  out  1  low once the board is configured or shut up.
- D_OUT  out  4  config nibble for M68K_D[15:12].
- D_OE  out  1  drive D_OUT onto the bus.
- DTACK_RANGE  out  1  access is claimed; the top level pulls DTACK.
- RAMCE  out  1  RAM chip enable.

## Operation
- Configuration state register cfg_st has three states: UNCONF, CONF and SHUTUP. Reset forces UNCONF.
- base[3:0] holds the A23:20 of the RAM base and resets to 0.
- Cycle start is the rising edge at which AS_n is sampled low and was sampled high at the previous edge. At that edge the block latches:
  - hit_cfg = (A_HI == 8'hE8) and cfg_st == UNCONF and !CONFIG_IN_n;
  - hit_ram = cfg_st == CONF and base <= A_HI[7:4] < base + SIZE_MB. The sum is 5 bits wide so 8 MB at base 2 ends at $A, with no wrap;
  - idx = A_LO.
- The latched hit flags clear on the first rising edge at which AS_n is sampled high.
- Outputs are AND-gated with live !AS_n so they release as soon as AS_n rises:
  - RAMCE = hit_ram and !AS_n;
  - DTACK_RANGE = (hit_ram or hit_cfg) and !AS_n;
  - D_OE = hit_cfg and RW and !AS_n.
- Read nibble map. The offset is the byte address, i.e. idx*2.
  - $00 returns 4'hE (Zorro II, add to memlist).
  - $02 returns the size code: 8 MB = 0, 4 MB = 7, 2 MB = 6, 1 MB = 5.
  - $04/$06 return ~PRODUCT[7:4] / ~PRODUCT[3:0].
  - $10–$16 return ~MANUF_ID, high nibble first.
  - Offsets $40 and above return 4'h0.
  - All other offsets return 4'hF.
- Write commit happens on the rising edge at which UDS_n is sampled low after being sampled high, while hit_cfg is set and RW is low. Only offsets $48 and $4C act:
  - $48: base <= D_IN and cfg_st goes to CONF;
  - $4C: cfg_st goes to SHUTUP;
  - writes to any other offset are ignored.
- CONFIG_OUT_n = (cfg_st == UNCONF). In CONF and SHUTUP the config space no longer responds.

## Timing
- Reset values: CONFIG_OUT_n = 1, D_OUT = 4'hF, D_OE = 0, DTACK_RANGE = 0, RAMCE = 0.
- Decode latency: one rising edge after the AS_n fall is sampled. This is well before the 68000 S4 DTACK sample.
- Release: combinational on AS_n rising, giving zero added cycles.
- Write to CONF takes effect at the commit edge, so RAM hits begin on the next cycle start. A cycle already in progress is not re-decoded.
- Reset asserted mid-cycle clears every flag and output asynchronously. After release, a fresh AS_n falling edge is required; a strobe already low at release does not count as a cycle start.
- AS_n and UDS_n falling together: both are detected on the same edge, and the write commits using the hit_cfg latched on that edge.
- CONFIG_IN_n rising while in UNCONF: new cycles stop hitting; the state is kept.

## Structure
- A shared package zorro_pkg holds:
  - the cfg_st enum;
  - the constants for the $E8 region and the offsets $48, $4C, $40;
  - the size-code function of SIZE_MB.
- A single sub-module, zorro_cfg_rom, provides the combinational idx-to-nibble map. It is parameterised by SIZE_MB, MANUF_ID and PRODUCT.

## Test plan
- Read $E80000, then $E80002, with SIZE_MB = 8 → D_OUT = E then 0; D_OE and DTACK_RANGE high one edge after AS_n falls; both low immediately when AS_n rises.
- Write 4'h2 to $E80048 → CONFIG_OUT_n low; a read at $200000 gives RAMCE = 1; reads at $9FFFFE hit; $A00000 and $1FFFFE do not.
- Write to $E8004C while UNCONF → SHUTUP; CONFIG_OUT_n low; subsequent reads at $E80000 and $200000 give D_OE = 0 and RAMCE = 0.
- CONFIG_IN_n = 1, read $E80000 → no D_OE, no DTACK_RANGE; after CONFIG_IN_n goes low the next read returns E.
- Assert M68K_RESET_n low mid RAM cycle → RAMCE and DTACK_RANGE drop asynchronously, cfg_st = UNCONF, and RAM at $200000 is no longer decoded.
- Simultaneous AS_n/UDS_n fall writing 4'h4 to $E80048 with SIZE_MB = 4 → base = 4, and $400000–$7FFFFE hit.
